// File: rtl/inner_loop_acc.sv
// inner_loop_acc: folds one redundant (r0,r1) partial-product pair per b-digit
// into a running accumulator, retiring the low radix bits of the sum as a digit.
// The three operands are compressed to sum/carry vectors, then carry-propagated
// one CHUNK-wide slice per cycle so that the adder depth stays bounded.
// Optional build macro: INNER_ACC_OVF_CHECK_EN adds a sticky overflow flag that
// catches sum bits lost above the accumulator width. Without it, ovf_o is tied low.
//
// state | meaning
// IDLE  | waiting for en_i; operands and base accumulator latched on en_i
// CSA   | 3:2 compression of base, r0, r1 into sum/carry vectors
// ADD   | carry-propagate one chunk per cycle, idx 0..NCH-1
// RET   | done pulse; digit and shifted accumulator are visible this cycle
module inner_loop_acc #(
  parameter int Size  = 3072,
  parameter int radix = 108,
  parameter int CHUNK = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [Size+radix+1:0] r0_i,
  input  logic [Size+radix+1:0] r1_i,
  output logic [radix-1:0]      digit_out_o,
  output logic [Size+radix+2:0] acc_out_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic                  ovf_o
);

  localparam int IN_W  = Size + radix + 2;
  localparam int ACC_W = Size + radix + 3;
  localparam int NCH   = (ACC_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W = NCH * CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSA  = 2'd1,
    ADD  = 2'd2,
    RET  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     r0_q, r0_d;
  logic [IN_W-1:0]     r1_q, r1_d;
  logic [ACC_W-1:0]    base_q, base_d;
  logic [PAD_W-1:0]    s_q, s_d;
  logic [PAD_W-1:0]    c_q, c_d;
  logic [PAD_W-1:0]    sum_q, sum_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                cy_q, cy_d;
  logic [radix-1:0]    digit_q, digit_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                overrun_q, overrun_d;

  logic [PAD_W-1:0]    base_x, r0_x, r1_x;
  logic [CHUNK:0]      chunk_sum;
  logic [PAD_W-1:0]    full_sum;
  logic                last_add;
  int                  chunk_lo;

  // Chunk adder and the complete sum as it stands once the current chunk lands.
  always_comb begin
    chunk_lo  = int'(idx_q) * CHUNK;
    base_x    = PAD_W'(base_q);
    r0_x      = PAD_W'(r0_q);
    r1_x      = PAD_W'(r1_q);
    chunk_sum = {1'b0, s_q[chunk_lo +: CHUNK]} + {1'b0, c_q[chunk_lo +: CHUNK]}
              + {{CHUNK{1'b0}}, cy_q};
    full_sum  = sum_q;
    full_sum[chunk_lo +: CHUNK] = chunk_sum[CHUNK-1:0];
    last_add  = (state_q == ADD) && (idx_q == LAST_IDX);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    base_d    = base_q;
    s_d       = s_q;
    c_d       = c_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    digit_d   = digit_q;
    acc_d     = acc_q;
    overrun_d = overrun_q | (en_i & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (en_i) begin
          r0_d    = r0_i;
          r1_d    = r1_i;
          base_d  = clr_i ? '0 : acc_q;
          state_d = CSA;
        end
      end
      CSA: begin
        s_d     = base_x ^ r0_x ^ r1_x;
        c_d     = ((base_x & r0_x) | (base_x & r1_x) | (r0_x & r1_x)) << 1;
        idx_d   = '0;
        cy_d    = 1'b0;
        state_d = ADD;
      end
      ADD: begin
        sum_d = full_sum;
        cy_d  = chunk_sum[CHUNK];
        if (last_add) begin
          // Results are written on entry to RET so they are valid while done is high.
          idx_d   = '0;
          digit_d = full_sum[radix-1:0];
          acc_d   = ACC_W'(full_sum[ACC_W-1:radix]);
          state_d = RET;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RET: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      r0_q      <= '0;
      r1_q      <= '0;
      base_q    <= '0;
      s_q       <= '0;
      c_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      digit_q   <= '0;
      acc_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      base_q    <= base_d;
      s_q       <= s_d;
      c_q       <= c_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      cy_q      <= cy_d;
      digit_q   <= digit_d;
      acc_q     <= acc_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef INNER_ACC_OVF_CHECK_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: final carry out or any sum bit at or above ACC_W.
  always_comb begin
    ovf_d = ovf_q;
    if (last_add) begin
      ovf_d = ovf_q | chunk_sum[CHUNK] | (|full_sum[PAD_W-1:ACC_W]);
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign digit_out_o = digit_q;
  assign acc_out_o   = acc_q;
  assign done_o      = (state_q == RET);
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_inner_loop_acc.sv
// Directed bench for inner_loop_acc at default parameters (NCH = 13).
// Timing model: en is driven in cycle 0 and sampled at the next edge; the
// unit spends one cycle in CSA, 13 in ADD and one in RET, so done is high in
// cycle 15 and busy is high for cycles 1..15.
module tb_inner_loop_acc;

  localparam int SIZE  = 3072;
  localparam int RADIX = 108;
  localparam int IN_W  = SIZE + RADIX + 2;
  localparam int ACC_W = SIZE + RADIX + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [IN_W-1:0]  r0;
  logic [IN_W-1:0]  r1;
  logic [RADIX-1:0] digit_out;
  logic [ACC_W-1:0] acc_out;
  logic             done;
  logic             busy;
  logic             overrun;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inner_loop_acc dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .clr_i       (clr),
    .r0_i        (r0),
    .r1_i        (r1),
    .digit_out_o (digit_out),
    .acc_out_o   (acc_out),
    .done_o      (done),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .ovf_o       (ovf)
  );

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full pass; optionally inject a stray en at cycle ovr_cyc or in the done cycle.
  task automatic run_pass(input string tag, input logic clr_v,
                          input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                          input logic [ACC_W-1:0] exp_digit, input logic [ACC_W-1:0] exp_acc,
                          input int ovr_cyc, input bit en_at_done);
    int lat;
    int busy_cnt;
    bit seen;
    lat = 0;
    busy_cnt = 0;
    seen = 1'b0;
    en = 1'b1;
    clr = clr_v;
    r0 = a;
    r1 = b;
    for (int i = 1; i <= 40; i++) begin
      tick();
      en = 1'b0;
      clr = 1'b0;
      if (i == ovr_cyc) begin
        en = 1'b1;
        r0 = ~a;
      end
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        lat = i;
        if (en_at_done) en = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, ACC_W'(seen), ACC_W'(1));
    check({tag, "_latency"}, ACC_W'(lat), ACC_W'(15));
    check({tag, "_busy_cycles"}, ACC_W'(busy_cnt), ACC_W'(15));
    check({tag, "_digit"}, ACC_W'(digit_out), exp_digit);
    check({tag, "_acc"}, acc_out, exp_acc);
    tick();
    en = 1'b0;
    check({tag, "_idle_after"}, ACC_W'({busy, done}), ACC_W'(0));
  endtask

  logic [IN_W-1:0] va;
  logic [IN_W-1:0] vb;
  logic [ACC_W-1:0] ea;
  int done_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    clr = 1'b1;
    r0 = IN_W'(5);
    r1 = IN_W'(3);

    // T1: reset held with en high
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_rst_flags", ACC_W'({done, busy, overrun, ovf}), ACC_W'(0));
      check("t1_rst_digit", ACC_W'(digit_out), ACC_W'(0));
      check("t1_rst_acc", acc_out, ACC_W'(0));
    end
    rst_n = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_rel_flags", ACC_W'({done, busy, overrun, ovf}), ACC_W'(0));
      check("t1_rel_acc", acc_out, ACC_W'(0));
    end

    // T2: single pass 5+3
    run_pass("t2", 1'b1, IN_W'(5), IN_W'(3), ACC_W'(8), ACC_W'(0), 0, 1'b0);

    // T3: carry ripples out of chunk 0, S = 2^256
    va = '0;
    va[255:0] = '1;
    ea = '0;
    ea[148] = 1'b1;
    run_pass("t3", 1'b1, va, IN_W'(1), ACC_W'(0), ea, 0, 1'b0);

    // T4: retire/shift over two passes, then clr alone must not touch acc
    va = '0;
    va[108] = 1'b1;
    va[2:0] = 3'd7;
    run_pass("t4a", 1'b1, va, IN_W'(0), ACC_W'(7), ACC_W'(1), 0, 1'b0);
    clr = 1'b1;
    tick();
    tick();
    tick();
    clr = 1'b0;
    check("t4_clr_no_en_acc", acc_out, ACC_W'(1));
    check("t4_clr_no_en_busy", ACC_W'(busy), ACC_W'(0));
    run_pass("t4b", 1'b0, IN_W'(1), IN_W'(1), ACC_W'(3), ACC_W'(0), 0, 1'b0);
    check("t4_overrun_clear", ACC_W'(overrun), ACC_W'(0));

    // en in the done cycle: ignored, flags overrun
    run_pass("ret_en", 1'b1, IN_W'(9), IN_W'(6), ACC_W'(15), ACC_W'(0), 0, 1'b1);
    check("ret_en_overrun", ACC_W'(overrun), ACC_W'(1));

    do_reset();
    check("rst_clears_overrun", ACC_W'(overrun), ACC_W'(0));

    // T5: stray en mid-pass with a different r0
    run_pass("t5", 1'b1, IN_W'(10), IN_W'(20), ACC_W'(30), ACC_W'(0), 4, 1'b0);
    check("t5_overrun_set", ACC_W'(overrun), ACC_W'(1));
    run_pass("t5_next", 1'b1, IN_W'(2), IN_W'(0), ACC_W'(2), ACC_W'(0), 0, 1'b0);
    check("t5_overrun_sticky", ACC_W'(overrun), ACC_W'(1));

    // Mid-pass reset: acc = 3 first, then abort a pass at cycle 7
    va = '0;
    va[109:108] = 2'd3;
    run_pass("mr_pre", 1'b1, va, IN_W'(0), ACC_W'(0), ACC_W'(3), 0, 1'b0);
    en = 1'b1;
    clr = 1'b0;
    r0 = IN_W'(5);
    r1 = IN_W'(0);
    done_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      en = 1'b0;
      if (done) done_cnt++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_busy", ACC_W'(busy), ACC_W'(0));
    check("mr_acc", acc_out, ACC_W'(0));
    check("mr_overrun", ACC_W'(overrun), ACC_W'(0));
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("mr_no_done", ACC_W'(done_cnt), ACC_W'(0));
    va = '0;
    va[108] = 1'b1;
    va[2:0] = 3'd4;
    run_pass("mr_fresh", 1'b0, va, IN_W'(4), ACC_W'(8), ACC_W'(1), 0, 1'b0);

    // T6: acc = 2, then r0 = r1 = all ones gives S = 2^ACC_W exactly
    check("t6_ovf_before", ACC_W'(ovf), ACC_W'(0));
    va = '0;
    va[109] = 1'b1;
    run_pass("t6a", 1'b1, va, IN_W'(0), ACC_W'(0), ACC_W'(2), 0, 1'b0);
    check("t6_ovf_mid", ACC_W'(ovf), ACC_W'(0));
    vb = '1;
    run_pass("t6b", 1'b0, vb, vb, ACC_W'(0), ACC_W'(0), 0, 1'b0);
`ifdef INNER_ACC_OVF_CHECK_EN
    ea = ACC_W'(1);
`else
    ea = ACC_W'(0);
`endif
    check("t6_ovf_after", ACC_W'(ovf), ea);
    tick();
    check("t6_ovf_sticky", ACC_W'(ovf), ea);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
